// File: rtl/frame_buffer_pp.sv
// frame_buffer_pp: two-bank ping-pong frame buffer for the median-filter path.
// A raster pixel stream fills one bank while the other, already complete,
// streams out through a registered valid/ready output with frame/line markers.
module frame_buffer_pp #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic [1:0]            frames_stored
);

    localparam int                    DEPTH     = IMG_W * IMG_H;
    localparam int                    RAM_WORDS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam int                    XW        = $clog2(IMG_W);
    localparam logic [XW-1:0]         LAST_X    = XW'(IMG_W - 1);

    logic [DATA_WIDTH-1:0] bank0 [RAM_WORDS];
    logic [DATA_WIDTH-1:0] bank1 [RAM_WORDS];

    logic [1:0]            full;
    logic [1:0]            full_next;
    logic                  wsel;
    logic                  rsel;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [XW-1:0]         rx;

    logic                  wr_fire;
    logic                  wr_last;
    logic                  rd_fire;
    logic                  rd_last;

    assign in_ready      = !full[wsel];
    assign wr_fire       = in_valid && in_ready;
    assign wr_last       = wr_fire && (wptr == LAST_ADDR);
    assign rd_fire       = full[rsel] && (!out_valid || out_ready);
    assign rd_last       = rd_fire && (rptr == LAST_ADDR);
    assign frames_stored = {1'b0, full[0]} + {1'b0, full[1]};

    // Writer and reader each touch only their own bank's flag, so a frame
    // completing and a frame releasing in the same cycle never collide.
    always_comb begin
        full_next = full;
        if (wr_last) begin
            full_next[wsel] = 1'b1;
        end
        if (rd_last) begin
            full_next[rsel] = 1'b0;
        end
    end

    // Bank RAM write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (wsel) begin
                bank1[wptr] <= in_data;
            end else begin
                bank0[wptr] <= in_data;
            end
        end
    end

    // Frame flags, bank selects and address counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
            wsel <= 1'b0;
            rsel <= 1'b0;
            wptr <= '0;
            rptr <= '0;
            rx   <= '0;
        end else begin
            full <= full_next;
            if (wr_fire) begin
                if (wr_last) begin
                    wptr <= '0;
                    wsel <= !wsel;
                end else begin
                    wptr <= wptr + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_last) begin
                    rptr <= '0;
                    rsel <= !rsel;
                end else begin
                    rptr <= rptr + 1'b1;
                end
                if (rd_last || (rx == LAST_X)) begin
                    rx <= '0;
                end else begin
                    rx <= rx + 1'b1;
                end
            end
        end
    end

    // Output register doubles as the synchronous RAM read stage; it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (rd_fire) begin
            out_valid <= 1'b1;
            out_data  <= rsel ? bank1[rptr] : bank0[rptr];
            out_sof   <= (rptr == '0);
            out_eol   <= (rx == LAST_X);
            out_eof   <= (rptr == LAST_ADDR);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
